pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer with return-address stack (RAS); replaces the plain PC register.
//  Each cycle it selects the next fetch address: reset vector, hold, increment, relative branch, absolute jump, call or return.
//  Sits between the decode/branch-resolve logic and the instruction-memory address port.
// PARAMETERS
//  WIDTH      16   address width in bits
//  RESET_VEC  0    adr_out value after reset (WIDTH bits)
//  STEP       1    sequential increment per instruction
//  RAS_DEPTH  4    return-address stack entries (power of 2, >=2)
// PORTS
//  clk         in   1      single clock, all state updates on posedge
//  rst         in   1      synchronous, active-high reset
//  stall       in   1      hold PC and RAS this cycle
//  branch_en   in   1      relative branch: PC <= PC + branch_off
//  branch_off  in   WIDTH  signed two's-complement offset
//  jump_en     in   1      absolute jump: PC <= jump_adr
//  jump_adr    in   WIDTH  jump/call target
//  call_en     in   1      push PC+STEP, PC <= jump_adr
//  ret_en      in   1      pop top of RAS into PC
//  adr_out     out  WIDTH  current fetch address (registered)
//  next_adr    out  WIDTH  combinational preview of value loaded at next posedge
//  ras_count   out  $clog2(RAS_DEPTH)+1  valid RAS entries
//  ras_ovf     out  1      sticky: call issued while RAS full
//  ras_unf     out  1      sticky: ret issued while RAS empty
// BEHAVIOUR
//  Reset (rst=1 at posedge, overrides all): adr_out=RESET_VEC, ras_count=0, ras_ovf=0, ras_unf=0, RAS write ptr=0.
//  Priority each cycle: rst > stall > ret_en > call_en > jump_en > branch_en > increment.
//  stall=1: adr_out, RAS, ras_count, sticky flags unchanged; all other controls ignored; next_adr=adr_out.
//  Increment: adr_out <= adr_out + STEP.
//  Branch: adr_out <= adr_out + branch_off.
//  Jump: adr_out <= jump_adr.
//  Call: push adr_out+STEP; adr_out <= jump_adr.
//   RAS full: write at wrapping ptr (oldest entry overwritten), ras_count stays RAS_DEPTH, ras_ovf <= 1.
//  Return, ras_count>0: adr_out <= top entry; ptr decrements (wraps); ras_count-1.
//   RAS empty: adr_out <= adr_out+STEP (fall through), ras_count stays 0, ras_unf <= 1.
//  Simultaneous ret_en and call_en: ret wins; call ignored entirely (no push).
//  Arithmetic: all address sums modulo 2^WIDTH; carries dropped; no flags. 16'hFFFF+1 -> 16'h0000.
//  RAS storage as circular buffer, WIDTH bits/entry; ptr wraps modulo RAS_DEPTH.
//  Latency: control at posedge N -> adr_out at N+1; next_adr equals that value during cycle N.
//  Sticky flags clear only on rst.
//  Simulation-only $display trace allowed under `ifdef SIM; no effect on synthesis.
// TESTING
//  1 Reset RESET_VEC=16'h0010, 3 idle cycles -> adr_out 0x10,0x11,0x12,0x13; next_adr leads adr_out by one.
//  2 At PC=0x20, branch_en, branch_off=16'hFFFC -> PC=0x1C; at PC=0xFFFF, increment -> 0x0000.
//  3 call jump_adr=0x100 at PC=0x40; call 0x200 at 0x100; ret; ret -> PC 0x100,0x200,0x101,0x41; ras_count 1,2,1,0.
//  4 5 calls with RAS_DEPTH=4 -> ras_ovf=1, ras_count=4; 4 rets return newest 4 addresses in LIFO order; 5th ret -> PC+1, ras_unf=1.
//  5 stall held 3 cycles with branch_en/call_en asserted -> adr_out, ras_count unchanged; ret_en+call_en same cycle -> pop only.
//  6 rst asserted mid-call sequence (ras_count=2, flags set) -> next cycle adr_out=RESET_VEC, ras_count=0, flags 0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch address each cycle and keeps
// a circular return-address stack for call/return.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               STEP      = 1,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         branch_en,
    input  logic [WIDTH-1:0]             branch_off,
    input  logic                         jump_en,
    input  logic [WIDTH-1:0]             jump_adr,
    input  logic                         call_en,
    input  logic                         ret_en,
    output logic [WIDTH-1:0]             adr_out,
    output logic [WIDTH-1:0]             next_adr,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    logic [WIDTH-1:0] adr_q, adr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] seq_adr;
    logic [PW-1:0]    top_ptr;
    logic             push;

    // ptr_q is the next free slot; the top of stack sits one below it.
    assign seq_adr = adr_q + STEP_W;
    assign top_ptr = ptr_q - PW'(1);

    always_comb begin
        adr_d = seq_adr;
        cnt_d = cnt_q;
        ptr_d = ptr_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (stall) begin
            adr_d = adr_q;
        end else if (ret_en) begin
            if (cnt_q != '0) begin
                adr_d = ras_q[top_ptr];
                ptr_d = top_ptr;
                cnt_d = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end else if (call_en) begin
            push  = 1'b1;
            adr_d = jump_adr;
            ptr_d = ptr_q + PW'(1);
            // A full stack overwrites its oldest entry, which is the slot at ptr_q.
            if (cnt_q == FULL) ovf_d = 1'b1;
            else               cnt_d = cnt_q + CW'(1);
        end else if (jump_en) begin
            adr_d = jump_adr;
        end else if (branch_en) begin
            adr_d = adr_q + branch_off;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q <= RESET_VEC;
            cnt_q <= '0;
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            adr_q <= adr_d;
            cnt_q <= cnt_d;
            ptr_q <= ptr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) ras_q[ptr_q] <= seq_adr;
    end

    assign adr_out   = adr_q;
    assign next_adr  = rst ? RESET_VEC : adr_d;
    assign ras_count = cnt_q;
    assign ras_ovf   = ovf_q;
    assign ras_unf   = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: expected PC/RAS state is queued when each
// step is driven and compared after the following clock edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst, stall, branch_en, jump_en, call_en, ret_en;
    logic [15:0] branch_off, jump_adr;
    logic [15:0] adr_out, next_adr;
    logic [2:0]  ras_count;
    logic        ras_ovf, ras_unf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] adr;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;
    exp_t exp_q[$];

    pc_sequencer #(.WIDTH(16), .RESET_VEC(16'h0010), .STEP(1), .RAS_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .branch_en(branch_en), .branch_off(branch_off),
        .jump_en(jump_en), .jump_adr(jump_adr),
        .call_en(call_en), .ret_en(ret_en),
        .adr_out(adr_out), .next_adr(next_adr),
        .ras_count(ras_count), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of controls, check the preview, then check the registered result.
    task automatic step(input string tag, input logic r, input logic st,
                        input logic br, input logic [15:0] off,
                        input logic jp, input logic [15:0] ja,
                        input logic cl, input logic rt,
                        input logic [15:0] e_adr, input logic [2:0] e_cnt,
                        input logic e_ovf, input logic e_unf);
        exp_t e;
        logic [15:0] held;
        @(negedge clk);
        rst = r; stall = st; branch_en = br; branch_off = off;
        jump_en = jp; jump_adr = ja; call_en = cl; ret_en = rt;
        e.adr = e_adr; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        exp_q.push_back(e);
        held = adr_out;
        #1;
        chk({tag, "/next_adr"}, {16'h0, next_adr}, {16'h0, e_adr});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "/adr_out"},   {16'h0, adr_out},  {16'h0, e.adr});
        chk({tag, "/ras_count"}, {29'h0, ras_count}, {29'h0, e.cnt});
        chk({tag, "/ras_ovf"},   {31'h0, ras_ovf},  {31'h0, e.ovf});
        chk({tag, "/ras_unf"},   {31'h0, ras_unf},  {31'h0, e.unf});
        if (st) chk({tag, "/stall_hold"}, {16'h0, adr_out}, {16'h0, held});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
        call_en = 1'b0; ret_en = 1'b0; branch_off = '0; jump_adr = '0;

        // Reset and idle increment
        step("rst0",  1, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0010, 3'd0, 0, 0);
        step("rst1",  1, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0010, 3'd0, 0, 0);
        step("idle1", 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0011, 3'd0, 0, 0);
        step("idle2", 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0012, 3'd0, 0, 0);
        step("idle3", 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0013, 3'd0, 0, 0);

        // Branch backwards and wrap at top of address space
        step("jmp20", 0, 0, 0, 16'h0,    1, 16'h0020, 0, 0, 16'h0020, 3'd0, 0, 0);
        step("brneg", 0, 0, 1, 16'hFFFC, 0, 16'h0,    0, 0, 16'h001C, 3'd0, 0, 0);
        step("jmpff", 0, 0, 0, 16'h0,    1, 16'hFFFF, 0, 0, 16'hFFFF, 3'd0, 0, 0);
        step("wrap",  0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0000, 3'd0, 0, 0);
        step("jbpri", 0, 0, 1, 16'h0100, 1, 16'h0040, 0, 0, 16'h0040, 3'd0, 0, 0);

        // Nested call / return
        step("call1", 0, 0, 0, 16'h0,    0, 16'h0100, 1, 0, 16'h0100, 3'd1, 0, 0);
        step("call2", 0, 0, 0, 16'h0,    0, 16'h0200, 1, 0, 16'h0200, 3'd2, 0, 0);
        step("ret1",  0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0101, 3'd1, 0, 0);
        step("ret2",  0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0041, 3'd0, 0, 0);

        // Overflow: five calls into a four-entry stack, then drain and underflow
        step("ov_c1", 0, 0, 0, 16'h0,    0, 16'h0300, 1, 0, 16'h0300, 3'd1, 0, 0);
        step("ov_c2", 0, 0, 0, 16'h0,    0, 16'h0400, 1, 0, 16'h0400, 3'd2, 0, 0);
        step("ov_c3", 0, 0, 0, 16'h0,    0, 16'h0500, 1, 0, 16'h0500, 3'd3, 0, 0);
        step("ov_c4", 0, 0, 0, 16'h0,    0, 16'h0600, 1, 0, 16'h0600, 3'd4, 0, 0);
        step("ov_c5", 0, 0, 0, 16'h0,    0, 16'h0700, 1, 0, 16'h0700, 3'd4, 1, 0);
        step("ov_r1", 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0601, 3'd3, 1, 0);
        step("ov_r2", 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0501, 3'd2, 1, 0);
        step("ov_r3", 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0401, 3'd1, 1, 0);
        step("ov_r4", 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0301, 3'd0, 1, 0);
        step("unf",   0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0302, 3'd0, 1, 1);

        // Stall ignores other controls; ret beats call in the same cycle
        step("s_call", 0, 0, 0, 16'h0,   0, 16'h0800, 1, 0, 16'h0800, 3'd1, 1, 1);
        for (int i = 0; i < 3; i++)
            step("stall", 0, 1, 1, 16'h0010, 0, 16'h0900, 1, 0, 16'h0800, 3'd1, 1, 1);
        step("retcall", 0, 0, 0, 16'h0,  0, 16'h0900, 1, 1, 16'h0303, 3'd0, 1, 1);
        step("rc_call", 0, 0, 0, 16'h0,  0, 16'h0A00, 1, 0, 16'h0A00, 3'd1, 1, 1);
        step("rc_ret",  0, 0, 0, 16'h0,  0, 16'h0,    0, 1, 16'h0304, 3'd0, 1, 1);

        // Reset in the middle of a call sequence
        step("m_c1",  0, 0, 0, 16'h0,    0, 16'h0B00, 1, 0, 16'h0B00, 3'd1, 1, 1);
        step("m_c2",  0, 0, 0, 16'h0,    0, 16'h0C00, 1, 0, 16'h0C00, 3'd2, 1, 1);
        step("m_rst", 1, 0, 0, 16'h0,    0, 16'h0D00, 1, 0, 16'h0010, 3'd0, 0, 0);
        step("m_inc", 0, 0, 0, 16'h0,    0, 16'h0,    0, 0, 16'h0011, 3'd0, 0, 0);
        step("m_ret", 0, 0, 0, 16'h0,    0, 16'h0,    0, 1, 16'h0012, 3'd0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
